// File: rtl/ldm_writeback_sequencer_pkg.sv
// Shared definitions for the LDM write-back sequencer: FSM state encoding,
// word size and a register-list population count.
package ldm_pkg;

  // Bytes per memory word; addresses advance by this amount per register.
  localparam int WORD_BYTES = 4;

  // Widest register list the helpers accept (a 4-bit index reaches 16 slots).
  localparam int LIST_MAX = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_BASE = 3'd3,
    ST_DONE = 3'd4
  } ldm_state_t;

  // Number of set bits in a register list (narrower lists are zero-extended).
  function automatic logic [4:0] popcount(input logic [LIST_MAX-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < LIST_MAX; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_writeback_sequencer_lsb.sv
// Priority encoder returning the index of the lowest set bit of a register
// list, plus a flag telling whether any bit is set at all.
module lowest_set_bit_encoder #(
  parameter int NUM_REGS = 15
) (
  input  logic [NUM_REGS-1:0] i_vec,
  output logic [3:0]          o_idx,
  output logic                o_valid
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_writeback_sequencer.sv
// LDM write-back sequencer: walks a register list, issues one word read per
// listed register, writes each returned word to the register file in
// ascending register order and optionally writes back the updated base.
module ldm_writeback_sequencer
  import ldm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic [DATA_W-1:0]   base_addr,
  input  logic [3:0]          base_reg,
  input  logic                pre,
  input  logic                up,
  input  logic                wback,
  output logic                busy,
  output logic                mem_req,
  output logic [DATA_W-1:0]   mem_addr,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                wb_en,
  output logic [3:0]          wb_dest,
  output logic [DATA_W-1:0]   wb_value,
  output logic                done
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

  ldm_state_t            r_state;
  logic [NUM_REGS-1:0]   r_list;
  logic [3:0]            r_base_reg;
  logic                  r_do_base;
  logic [DATA_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_final_base;
  logic                  r_wb_en;
  logic [3:0]            r_wb_dest;
  logic [DATA_W-1:0]     r_wb_value;

  logic [3:0]            w_lsb_idx;
  logic                  w_lsb_vld;
  logic [NUM_REGS-1:0]   w_list_next;
  logic [LIST_MAX-1:0]   w_list_ext;
  logic [4:0]            w_cnt;
  logic [DATA_W-1:0]     w_span;
  logic [DATA_W-1:0]     w_start_addr;
  logic [DATA_W-1:0]     w_final_base;
  logic                  w_base_listed;
  logic                  w_do_base;
  logic                  w_accept;

  lowest_set_bit_encoder #(
    .NUM_REGS (NUM_REGS)
  ) u_lsb (
    .i_vec   (r_list),
    .o_idx   (w_lsb_idx),
    .o_valid (w_lsb_vld)
  );

  assign w_list_ext  = LIST_MAX'(reg_list);
  assign w_cnt       = popcount(w_list_ext);
  assign w_span      = DATA_W'(w_cnt) * STEP;
  assign w_accept    = (r_state == ST_IDLE) && start;

  // The register just written is removed from the remaining list.
  assign w_list_next = r_list & ~(NUM_REGS'(1) << w_lsb_idx);

  // A listed base register keeps its loaded value; R15 is never written here.
  assign w_base_listed = w_list_ext[base_reg];
  assign w_do_base     = wback && (base_reg != 4'hF) && !w_base_listed;

  // Lowest register always maps to the lowest address, whatever the direction.
  always_comb begin
    w_start_addr = base_addr;
    case ({up, pre})
      2'b10:   w_start_addr = base_addr;
      2'b11:   w_start_addr = base_addr + STEP;
      2'b00:   w_start_addr = base_addr - w_span + STEP;
      default: w_start_addr = base_addr - w_span;
    endcase
    w_final_base = up ? (base_addr + w_span) : (base_addr - w_span);
  end

  // Control FSM and register-file write port; reset aborts any block load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_list     <= '0;
      r_base_reg <= '0;
      r_do_base  <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_value <= '0;
    end else begin
      r_wb_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_list     <= reg_list;
            r_base_reg <= base_reg;
            r_do_base  <= w_do_base;
            r_state    <= (w_cnt != 5'd0) ? ST_REQ : ST_DONE;
          end
        end
        ST_REQ: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid && w_lsb_vld) begin
            r_wb_en    <= 1'b1;
            r_wb_dest  <= w_lsb_idx;
            r_wb_value <= mem_rdata;
            r_list     <= w_list_next;
            if (w_list_next != '0)
              r_state <= ST_REQ;
            else if (r_do_base)
              r_state <= ST_BASE;
            else
              r_state <= ST_DONE;
          end
        end
        ST_BASE: begin
          r_wb_en    <= 1'b1;
          r_wb_dest  <= r_base_reg;
          r_wb_value <= r_final_base;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          // Hold here while the final write is still on the port, so done
          // lands in the cycle after it.
          if (!r_wb_en)
            r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address walker and final-base capture; pure data, only meaningful when busy.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr       <= w_start_addr;
      r_final_base <= w_final_base;
    end else if ((r_state == ST_WAIT) && mem_rvalid) begin
      r_addr <= r_addr + STEP;
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign mem_req  = (r_state == ST_REQ);
  assign mem_addr = (r_state == ST_REQ) ? r_addr : '0;
  assign wb_en    = r_wb_en;
  assign wb_dest  = r_wb_dest;
  assign wb_value = r_wb_value;
  assign done     = (r_state == ST_DONE) && !r_wb_en;

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
// Bench for ldm_writeback_sequencer: a latency-programmable memory, an event
// monitor and a list-level reference model of the block load.
module tb_ldm_writeback_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [14:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  base_reg = '0;
  logic        pre = 1'b0;
  logic        up = 1'b0;
  logic        wback = 1'b0;
  logic        busy, mem_req, wb_en, done;
  logic [31:0] mem_addr, wb_value;
  logic [3:0]  wb_dest;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int t0 = 0;
  bit mon_en = 1'b0;

  int          mem_lat = 1;
  logic [31:0] mem_salt = 32'h1357_9BDF;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_paddr = '0;

  logic [31:0] obs_req_addr[$];
  int          obs_req_t[$];
  int          obs_wb_dest[$];
  logic [31:0] obs_wb_val[$];
  int          obs_wb_t[$];
  int          obs_done_t[$];
  int          obs_busy;

  logic [31:0] exp_req_addr[$];
  int          exp_req_t[$];
  int          exp_wb_dest[$];
  logic [31:0] exp_wb_val[$];
  int          exp_wb_t[$];
  int          exp_done_t;
  int          exp_busy;

  ldm_writeback_sequencer #(.DATA_W(32), .NUM_REGS(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .base_reg   (base_reg),
    .pre        (pre),
    .up         (up),
    .wback      (wback),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ mem_salt ^ 32'h5A00_0000;
  endfunction

  // Memory: a request seen in cycle c returns data in cycle c+mem_lat.
  always @(negedge clk) begin
    if (rst) begin
      mem_pend   <= 1'b0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      if (mem_pend && mem_cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= memval(mem_paddr);
        mem_pend   <= 1'b0;
      end else if (mem_pend) begin
        mem_cnt <= mem_cnt - 1;
      end
      if (mem_req) begin
        mem_pend  <= 1'b1;
        mem_cnt   <= mem_lat;
        mem_paddr <= mem_addr;
      end
    end
  end

  // Monitor: record every output event with its cycle relative to start.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req) begin
        obs_req_addr.push_back(mem_addr);
        obs_req_t.push_back(cyc - t0);
      end
      if (wb_en) begin
        obs_wb_dest.push_back(int'(wb_dest));
        obs_wb_val.push_back(wb_value);
        obs_wb_t.push_back(cyc - t0);
      end
      if (done) obs_done_t.push_back(cyc - t0);
      if (busy) obs_busy = obs_busy + 1;
    end
  end

  task automatic clear_obs();
    obs_req_addr.delete(); obs_req_t.delete();
    obs_wb_dest.delete(); obs_wb_val.delete(); obs_wb_t.delete();
    obs_done_t.delete(); obs_busy = 0;
  endtask

  // Reference model: expected requests, writes and completion timing.
  task automatic build_expected(input logic [14:0] l, input logic [31:0] b,
                                input logic [3:0] br, input logic p, input logic u,
                                input logic w, input int lat);
    int n, k, last;
    logic [31:0] lo, a;
    bit listed;
    exp_req_addr.delete(); exp_req_t.delete();
    exp_wb_dest.delete(); exp_wb_val.delete(); exp_wb_t.delete();
    n = $countones(l);
    if (u) lo = p ? b + 32'd4 : b;
    else   lo = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (l[i]) begin
        a = lo + 32'(4 * k);
        exp_req_addr.push_back(a);
        exp_req_t.push_back(1 + k * (lat + 1));
        exp_wb_dest.push_back(i);
        exp_wb_val.push_back(memval(a));
        exp_wb_t.push_back(1 + (k + 1) * (lat + 1));
        k++;
      end
    end
    last = (n == 0) ? 0 : 1 + n * (lat + 1);
    listed = (br == 4'd15) ? 1'b0 : l[br];
    if (n != 0 && w && br != 4'd15 && !listed) begin
      exp_wb_dest.push_back(int'(br));
      exp_wb_val.push_back(u ? b + 32'(4 * n) : b - 32'(4 * n));
      exp_wb_t.push_back(last + 1);
      last++;
    end
    exp_done_t = last + 1;
    exp_busy   = last + 1;
  endtask

  // Start one block load and collect events until done (bounded).
  task automatic run_op(input logic [14:0] l, input logic [31:0] b, input logic [3:0] br,
                        input logic p, input logic u, input logic w, input int lat,
                        input int restart_rel);
    int n;
    bit got;
    clear_obs();
    mem_lat = lat;
    @(negedge clk);
    reg_list = l; base_addr = b; base_reg = br; pre = p; up = u; wback = w;
    start = 1'b1;
    t0 = cyc;
    mon_en = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      start = (restart_rel > 0 && n == restart_rel);
      if (start) begin
        reg_list  = 15'($urandom) | 15'h0001;
        base_addr = $urandom;
      end
      if (obs_done_t.size() > 0) got = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL op_timeout: done seen=%0d, required done within 300 cycles", got);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, mem_req, wb_en, done} !== 4'b0 || mem_addr !== '0 || wb_dest !== '0 || wb_value !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b req=%b addr=%h wb_en=%b dest=%0d val=%h done=%b, required all 0",
               busy, mem_req, mem_addr, wb_en, wb_dest, wb_value, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_ascending();
    int ed[4] = '{0, 1, 4, 5};
    logic [31:0] ea[3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] ev;
    run_op(15'h0013, 32'h100, 4'd5, 1'b0, 1'b1, 1'b1, 1, 0);
    checks++;
    if (obs_req_addr.size() != 3 || obs_req_t[0] != 1) begin
      failures++;
      $display("FAIL asc_req_count: got %0d requests, required 3 with first in cycle 1", obs_req_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_req_addr[i] !== ea[i]) begin
          failures++;
          $display("FAIL asc_addr[%0d]: got %h, required %h", i, obs_req_addr[i], ea[i]);
        end
      end
    end
    checks++;
    if (obs_wb_dest.size() != 4) begin
      failures++;
      $display("FAIL asc_wb_count: got %0d, required 4", obs_wb_dest.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ev = (i == 3) ? 32'h10C : memval(ea[i]);
        checks++;
        if (obs_wb_dest[i] != ed[i] || obs_wb_val[i] !== ev) begin
          failures++;
          $display("FAIL asc_wb[%0d]: got R%0d=%h, required R%0d=%h", i, obs_wb_dest[i], obs_wb_val[i], ed[i], ev);
        end
      end
    end
    checks++;
    if (obs_done_t.size() != 1 || obs_done_t[0] != 9 || obs_busy != 9) begin
      failures++;
      $display("FAIL asc_done: got %0d pulses first at %0d busy=%0d, required 1 pulse at 9 busy=9",
               obs_done_t.size(), (obs_done_t.size() > 0) ? obs_done_t[0] : -1, obs_busy);
    end
  endtask

  task automatic test_descending_pre();
    run_op(15'h0006, 32'h200, 4'd3, 1'b1, 1'b0, 1'b1, 1, 0);
    checks++;
    if (obs_req_addr.size() != 2 || obs_req_addr[0] !== 32'h1F8 || obs_req_addr[1] !== 32'h1FC) begin
      failures++;
      $display("FAIL desc_addr: got %0d requests, required 0x1F8 then 0x1FC", obs_req_addr.size());
    end
    checks++;
    if (obs_wb_dest.size() != 3 || obs_wb_dest[0] != 1 || obs_wb_dest[1] != 2 || obs_wb_dest[2] != 3
        || obs_wb_val[1] !== memval(32'h1FC) || obs_wb_val[2] !== 32'h1F8) begin
      failures++;
      $display("FAIL desc_wb: got %0d writes, required R1, R2=%h, R3=000001f8", obs_wb_dest.size(), memval(32'h1FC));
    end
  endtask

  task automatic test_base_conflict();
    run_op(15'h0009, 32'h300, 4'd3, 1'b0, 1'b1, 1'b1, 1, 0);
    checks++;
    if (obs_wb_dest.size() != 2 || obs_wb_dest[0] != 0 || obs_wb_dest[1] != 3
        || obs_wb_val[1] !== memval(32'h304)) begin
      failures++;
      $display("FAIL conflict_wb: got %0d writes, required only R0 and R3 with loaded data", obs_wb_dest.size());
    end
    checks++;
    if (obs_done_t.size() != 1 || obs_wb_t.size() != 2 || obs_done_t[0] != obs_wb_t[1] + 1) begin
      failures++;
      $display("FAIL conflict_done: got %0d done pulses, required one the cycle after the R3 write", obs_done_t.size());
    end
  endtask

  task automatic test_empty();
    run_op(15'h0000, 32'h400, 4'd2, 1'b0, 1'b1, 1'b1, 1, 0);
    checks++;
    if (obs_req_addr.size() != 0 || obs_wb_dest.size() != 0) begin
      failures++;
      $display("FAIL empty_access: got %0d requests %0d writes, required 0 and 0", obs_req_addr.size(), obs_wb_dest.size());
    end
    checks++;
    if (obs_done_t.size() != 1 || obs_done_t[0] != 1 || obs_busy != 1) begin
      failures++;
      $display("FAIL empty_done: got %0d pulses busy=%0d, required one pulse in cycle 1 busy=1", obs_done_t.size(), obs_busy);
    end
  endtask

  task automatic test_back_to_back();
    run_op(15'h0A05, 32'h8000_0010, 4'd9, 1'b0, 1'b0, 1'b1, 3, 3);
    build_expected(15'h0A05, 32'h8000_0010, 4'd9, 1'b0, 1'b0, 1'b1, 3);
    checks++;
    if (obs_wb_t.size() != exp_wb_t.size()) begin
      failures++;
      $display("FAIL b2b_wb_count: got %0d, required %0d", obs_wb_t.size(), exp_wb_t.size());
    end else begin
      for (int i = 0; i < exp_wb_t.size(); i++) begin
        checks++;
        if (obs_wb_t[i] != exp_wb_t[i] || obs_wb_dest[i] != exp_wb_dest[i] || obs_wb_val[i] !== exp_wb_val[i]) begin
          failures++;
          $display("FAIL b2b_wb[%0d]: got R%0d=%h at %0d, required R%0d=%h at %0d", i, obs_wb_dest[i],
                   obs_wb_val[i], obs_wb_t[i], exp_wb_dest[i], exp_wb_val[i], exp_wb_t[i]);
        end
      end
      checks++;
      if (obs_wb_t[1] - obs_wb_t[0] != 4) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d cycles, required 4", obs_wb_t[1] - obs_wb_t[0]);
      end
    end
    checks++;
    if (obs_done_t.size() != 1 || obs_done_t[0] != exp_done_t) begin
      failures++;
      $display("FAIL b2b_done: got %0d pulses, required 1 at cycle %0d", obs_done_t.size(), exp_done_t);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    mem_lat = 1;
    @(negedge clk);
    reg_list = 15'h0013; base_addr = 32'h100; base_reg = 4'd5; pre = 1'b0; up = 1'b1; wback = 1'b1;
    start = 1'b1;
    t0 = cyc;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_wb_dest.size() != 1 || busy !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre: got %0d writes busy=%b req=%b, required 1 write busy=1 req=0", obs_wb_dest.size(), busy, mem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_req, wb_en, done} !== 4'b0 || mem_addr !== '0 || wb_dest !== '0 || wb_value !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: busy=%b req=%b wb_en=%b dest=%0d val=%h done=%b, required all 0",
               busy, mem_req, wb_en, wb_dest, wb_value, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (obs_wb_dest.size() != 0 || obs_req_addr.size() != 0 || obs_done_t.size() != 0) begin
      failures++;
      $display("FAIL rstmid_quiet: got %0d writes %0d requests %0d done, required none",
               obs_wb_dest.size(), obs_req_addr.size(), obs_done_t.size());
    end
    run_op(15'h0110, 32'h0000_0040, 4'd2, 1'b1, 1'b1, 1'b1, 2, 0);
    build_expected(15'h0110, 32'h0000_0040, 4'd2, 1'b1, 1'b1, 1'b1, 2);
    checks++;
    if (obs_wb_dest != exp_wb_dest || obs_wb_val != exp_wb_val || obs_done_t.size() != 1 || obs_done_t[0] != exp_done_t) begin
      failures++;
      $display("FAIL rstmid_after: got %0d writes %0d done, required %0d writes done at %0d",
               obs_wb_dest.size(), obs_done_t.size(), exp_wb_dest.size(), exp_done_t);
    end
  endtask

  task automatic test_random();
    logic [14:0] l;
    logic [31:0] b;
    logic [3:0]  br;
    logic        p, u, w;
    int          lat, rs;
    for (int it = 0; it < 12; it++) begin
      mem_salt = $urandom;
      l   = ($urandom_range(0, 7) == 0) ? 15'h0000 : 15'($urandom);
      b   = $urandom;
      br  = 4'($urandom_range(0, 15));
      p   = 1'($urandom);
      u   = 1'($urandom);
      w   = 1'($urandom);
      lat = $urandom_range(1, 3);
      rs  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 5) : 0;
      run_op(l, b, br, p, u, w, lat, rs);
      build_expected(l, b, br, p, u, w, lat);
      checks++;
      if (obs_req_addr.size() != exp_req_addr.size() || obs_wb_dest.size() != exp_wb_dest.size()) begin
        failures++;
        $display("FAIL rnd%0d_counts: got %0d req %0d wb, required %0d req %0d wb (list=%h)", it,
                 obs_req_addr.size(), obs_wb_dest.size(), exp_req_addr.size(), exp_wb_dest.size(), l);
      end else begin
        for (int i = 0; i < exp_req_addr.size(); i++) begin
          checks++;
          if (obs_req_addr[i] !== exp_req_addr[i] || obs_req_t[i] != exp_req_t[i]) begin
            failures++;
            $display("FAIL rnd%0d_req[%0d]: got %h at %0d, required %h at %0d", it, i,
                     obs_req_addr[i], obs_req_t[i], exp_req_addr[i], exp_req_t[i]);
          end
        end
        for (int i = 0; i < exp_wb_dest.size(); i++) begin
          checks++;
          if (obs_wb_dest[i] != exp_wb_dest[i] || obs_wb_val[i] !== exp_wb_val[i] || obs_wb_t[i] != exp_wb_t[i]) begin
            failures++;
            $display("FAIL rnd%0d_wb[%0d]: got R%0d=%h at %0d, required R%0d=%h at %0d", it, i, obs_wb_dest[i],
                     obs_wb_val[i], obs_wb_t[i], exp_wb_dest[i], exp_wb_val[i], exp_wb_t[i]);
          end
        end
      end
      checks++;
      if (obs_done_t.size() != 1 || obs_done_t[0] != exp_done_t || obs_busy != exp_busy) begin
        failures++;
        $display("FAIL rnd%0d_done: got %0d pulses busy=%0d, required 1 at %0d busy=%0d", it,
                 obs_done_t.size(), obs_busy, exp_done_t, exp_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending_pre();
    test_base_conflict();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
